// File: rtl/featuremap_relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a single-channel fp32 raster stream.
// One pooled pixel is registered 1 cycle after each window's bottom-right input; no backpressure.
module featuremap_relu_maxpool #(
  parameter int data_width = 32,
  parameter int img_heigh  = 112,
  parameter int img_width  = 112
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [data_width-1:0] data_in,
  output logic                  valid_out,
  output logic [data_width-1:0] data_out,
  output logic                  done
);

  localparam int HALF_W = img_width / 2;
  localparam int CW     = (img_width > 1) ? $clog2(img_width) : 1;
  localparam int RW     = (img_heigh > 1) ? $clog2(img_heigh) : 1;
  localparam int LW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [data_width-1:0] hold_q, hold_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic [data_width-1:0] linebuf [HALF_W];
  logic [data_width-1:0] relu_val;
  logic [data_width-1:0] pair;
  logic [data_width-1:0] lb_rd;
  logic [LW-1:0]         lb_idx;
  logic                  col_last;
  logic                  row_last;
  logic                  lb_we;

  // Post-ReLU values are non-negative, so raw-bit unsigned compare orders them like floats.
  assign relu_val = data_in[data_width-1] ? '0 : data_in;
  assign pair     = (hold_q > relu_val) ? hold_q : relu_val;
  assign col_last = (col_q == CW'(img_width - 1));
  assign row_last = (row_q == RW'(img_heigh - 1));
  assign lb_idx   = LW'(col_q >> 1);
  assign lb_rd    = linebuf[lb_idx];
  assign lb_we    = valid_in && col_q[0] && !row_q[0];

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (!col_q[0]) begin
        hold_d = relu_val;
      end else if (row_q[0]) begin
        valid_d = 1'b1;
        dout_d  = (lb_rd > pair) ? lb_rd : pair;
        done_d  = row_last && col_last;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q   <= '0;
      row_q   <= '0;
      hold_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Even rows write, odd rows read: a write and a read never hit the same entry together.
  always_ff @(posedge clk) begin
    if (lb_we) linebuf[lb_idx] <= pair;
  end

  assign valid_out = valid_q;
  assign data_out  = dout_q;
  assign done      = done_q;

endmodule

// File: tb/tb_featuremap_relu_maxpool.sv
// Bench for featuremap_relu_maxpool: directed 4x4 table, hand-built corner sequences,
// and a full 112x112 random frame checked against a window-max reference model.
module tb_featuremap_relu_maxpool;

  localparam int BW = 112;
  localparam int BH = 112;
  localparam int NB = BW * BH;
  localparam int NBO = (BW / 2) * (BH / 2);

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_vin = 1'b0;
  logic [31:0] s_din = '0;
  logic        s_vout, s_done;
  logic [31:0] s_dout;
  logic        b_vin = 1'b0;
  logic [31:0] b_din = '0;
  logic        b_vout, b_done;
  logic [31:0] b_dout;

  always #5 clk = ~clk;

  featuremap_relu_maxpool #(.data_width(32), .img_heigh(4), .img_width(4)) u_small (
    .clk(clk), .reset(reset), .valid_in(s_vin), .data_in(s_din),
    .valid_out(s_vout), .data_out(s_dout), .done(s_done));

  featuremap_relu_maxpool u_big (
    .clk(clk), .reset(reset), .valid_in(b_vin), .data_in(b_din),
    .valid_out(b_vout), .data_out(b_dout), .done(b_done));

  int n_cmp = 0;
  int n_fail = 0;
  int done_seen = 0;

  bit          pend_v = 1'b0;
  logic [31:0] pend_d = '0;
  bit          pend_done = 1'b0;

  typedef struct {
    logic [31:0] din;
    bit          ev;
    logic [31:0] ed;
    bit          edone;
  } vec_t;
  vec_t tbl[16];

  logic [31:0] frame1 [16];
  logic [31:0] cur_frame [16];
  logic [31:0] pooled [4];
  logic [31:0] bigpix [NB];
  logic [31:0] bigref [NBO];
  logic [32:0] got_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  function automatic logic [31:0] max4(input logic [31:0] a, b, c, d);
    logic [31:0] m;
    m = relu(a);
    if (relu(b) > m) m = relu(b);
    if (relu(c) > m) m = relu(c);
    if (relu(d) > m) m = relu(d);
    return m;
  endfunction

  // Reference: each pooled pixel is the max of its 2x2 window after ReLU.
  task automatic model_small();
    for (int wr = 0; wr < 2; wr++)
      for (int wc = 0; wc < 2; wc++)
        pooled[wr*2+wc] = max4(cur_frame[(2*wr)*4 + 2*wc], cur_frame[(2*wr)*4 + 2*wc+1],
                               cur_frame[(2*wr+1)*4 + 2*wc], cur_frame[(2*wr+1)*4 + 2*wc+1]);
  endtask

  // One cycle: check what the previous cycle promised, then drive this cycle's input.
  task automatic step(input bit v, input logic [31:0] d, input bit ev,
                      input logic [31:0] ed, input bit edone);
    @(negedge clk);
    chk("valid_out", {31'b0, s_vout}, {31'b0, pend_v});
    if (pend_v) begin
      chk("data_out", s_dout, pend_d);
      chk("done", {31'b0, s_done}, {31'b0, pend_done});
    end else begin
      chk("done_idle", {31'b0, s_done}, 32'h0);
    end
    if (s_vout && s_done) done_seen++;
    s_vin = v;
    s_din = d;
    pend_v = ev;
    pend_d = ed;
    pend_done = edone;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic run_frame(input int max_gap, input int npix);
    int r, c;
    model_small();
    for (int i = 0; i < npix; i++) begin
      if (i > 0 && max_gap > 0) repeat ($urandom_range(max_gap, 1)) idle();
      r = i / 4;
      c = i % 4;
      step(1'b1, cur_frame[i], (r % 2 == 1) && (c % 2 == 1),
           pooled[(r/2)*2 + c/2], i == 15);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 16; i++) begin
      cur_frame[i] = $urandom;
      if ($urandom_range(3) != 0) cur_frame[i][31] = 1'b0;
    end
  endtask

  initial begin
    frame1 = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h3F000000,
               32'h40400000, 32'h3F000000, 32'h3F000000, 32'h40800000,
               32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000,
               32'h3F000000, 32'h3F000000, 32'h40000000, 32'h3F000000};
    for (int i = 0; i < 16; i++) tbl[i] = '{frame1[i], 1'b0, 32'h0, 1'b0};
    tbl[5]  = '{frame1[5],  1'b1, 32'h40400000, 1'b0};
    tbl[7]  = '{frame1[7],  1'b1, 32'h40800000, 1'b0};
    tbl[13] = '{frame1[13], 1'b1, 32'h3F000000, 1'b0};
    tbl[15] = '{frame1[15], 1'b1, 32'h40000000, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_vout", {31'b0, s_vout}, 32'h0);
    chk("rst_done", {31'b0, s_done}, 32'h0);
    chk("rst_dout", s_dout, 32'h0);
    chk("rst_big_dout", b_dout, 32'h0);
    reset = 1'b1;

    // Directed 4x4 table, continuous valid
    for (int i = 0; i < 16; i++) step(1'b1, tbl[i].din, tbl[i].ev, tbl[i].ed, tbl[i].edone);
    idle();

    // All negative with one -0.0: everything clamps to zero
    for (int i = 0; i < 16; i++) cur_frame[i] = 32'hC0A00000;
    cur_frame[6] = 32'h80000000;
    run_frame(0, 16);
    idle();
    chk("neg_zero_dout", s_dout, 32'h0);

    // Two frames back-to-back, second random
    done_seen = 0;
    cur_frame = frame1;
    run_frame(0, 16);
    rand_frame();
    run_frame(0, 16);
    idle();
    chk("b2b_done_cnt", done_seen, 32'd2);

    // Same frame with random idle gaps
    cur_frame = frame1;
    run_frame(3, 16);
    idle();

    // Reset mid-frame, then fresh frame
    rand_frame();
    run_frame(0, 6);
    idle();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_vout", {31'b0, s_vout}, 32'h0);
      chk("mid_rst_done", {31'b0, s_done}, 32'h0);
      chk("mid_rst_dout", s_dout, 32'h0);
    end
    reset = 1'b1;
    done_seen = 0;
    rand_frame();
    run_frame(0, 16);
    repeat (3) idle();
    chk("post_rst_done_cnt", done_seen, 32'd1);

    // Full-size random frame
    for (int i = 0; i < NB; i++) begin
      bigpix[i] = $urandom;
      if ($urandom_range(3) != 0) bigpix[i][31] = 1'b0;
    end
    for (int wr = 0; wr < BH/2; wr++)
      for (int wc = 0; wc < BW/2; wc++)
        bigref[wr*(BW/2)+wc] = max4(bigpix[(2*wr)*BW + 2*wc], bigpix[(2*wr)*BW + 2*wc+1],
                                    bigpix[(2*wr+1)*BW + 2*wc], bigpix[(2*wr+1)*BW + 2*wc+1]);
    for (int i = 0; i < NB + 4; i++) begin
      @(negedge clk);
      if (b_vout) got_q.push_back({b_done, b_dout});
      b_vin = (i < NB);
      b_din = (i < NB) ? bigpix[i] : 32'h0;
    end
    chk("big_count", got_q.size(), NBO);
    for (int k = 0; k < NBO && k < got_q.size(); k++) begin
      chk("big_dat", got_q[k][31:0], bigref[k]);
      chk("big_done", {31'b0, got_q[k][32]}, {31'b0, k == NBO - 1});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
